// File: rtl/tof_pkg.sv
// Shared types and constants for the log-domain time-of-flight echo detector.
package tof_pkg;

  parameter int unsigned LOG_W    = 21;
  parameter int unsigned LOG_FRAC = 16;
  parameter int unsigned TS_W     = 16;

  // 1.0 in Q5.16 (one octave, 6.02 dB)
  parameter logic [LOG_W-1:0] LOG_ONE = LOG_W'(1) << LOG_FRAC;

  typedef enum logic [2:0] {
    StIdle,
    StBlank,
    StSearch,
    StTrack,
    StDone
  } echo_state_t;

endpackage

// File: rtl/log_echo_detect_if.sv
// Control, sample stream and result bundle of the echo detector.
interface log_echo_detect_if #(
    parameter int unsigned LOG_W = tof_pkg::LOG_W,
    parameter int unsigned TS_W  = tof_pkg::TS_W
);

  logic             start;
  logic [LOG_W-1:0] thresh;
  logic [TS_W-1:0]  max_samples;
  logic             in_valid;
  logic [LOG_W-1:0] in_log;
  logic             busy;
  logic             done;
  logic             found;
  logic [TS_W-1:0]  tof;
  logic [LOG_W-1:0] peak_log;
  logic [LOG_W-1:0] noise_log;

  modport master (
    output start, thresh, max_samples, in_valid, in_log,
    input  busy, done, found, tof, peak_log, noise_log
  );

  modport slave (
    input  start, thresh, max_samples, in_valid, in_log,
    output busy, done, found, tof, peak_log, noise_log
  );

endinterface

// File: rtl/log_noise_floor.sv
// Exponential moving average of the log envelope, with init / update / freeze control.
module log_noise_floor #(
    parameter int unsigned LOG_W = tof_pkg::LOG_W,
    parameter int unsigned SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_i,
    input  logic             upd_i,
    input  logic [LOG_W-1:0] sample_i,
    output logic [LOG_W-1:0] noise_o
);

  logic [LOG_W-1:0]  noise_q, noise_d;
  logic signed [LOG_W:0] diff;
  logic signed [LOG_W:0] step;
  logic signed [LOG_W:0] sum;

  always_comb begin
    diff    = $signed({1'b0, sample_i}) - $signed({1'b0, noise_q});
    step    = diff >>> SHIFT;
    sum     = $signed({1'b0, noise_q}) + step;
    noise_d = noise_q;
    if (init_i) begin
      noise_d = sample_i;
    end else if (upd_i) begin
      // The step always moves toward the sample, so a negative sum cannot occur;
      // clamp anyway rather than wrap.
      noise_d = sum[LOG_W] ? '0 : sum[LOG_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      noise_q <= '0;
    end else begin
      noise_q <= noise_d;
    end
  end

  assign noise_o = noise_q;

endmodule

// File: rtl/log_echo_detect.sv
// First-echo detector: learns a log-domain noise floor, then reports the peak of the first
// echo that stays a programmable margin above it.
module log_echo_detect
  import tof_pkg::*;
#(
    parameter int unsigned LOG_W       = tof_pkg::LOG_W,
    parameter int unsigned TS_W        = tof_pkg::TS_W,
    parameter int unsigned BLANK       = 64,
    parameter int unsigned NOISE_SHIFT = 4,
    parameter int unsigned HOLD        = 4,
    parameter int unsigned END_HOLD    = 4
) (
    input logic               clk,
    input logic               rst,
    log_echo_detect_if.slave  bus
);

  localparam int unsigned RunW = $clog2(HOLD + 1);
  localparam int unsigned EndW = $clog2(END_HOLD + 1);

  localparam logic [TS_W-1:0] BlankLast = TS_W'(BLANK - 1);
  localparam logic [RunW-1:0] HoldCnt   = RunW'(HOLD);
  localparam logic [EndW-1:0] EndCnt    = EndW'(END_HOLD);

  echo_state_t      state_q, state_d;
  logic [LOG_W-1:0] thresh_q, thresh_d;
  logic [TS_W-1:0]  max_q, max_d;
  logic [TS_W-1:0]  idx_q, idx_d;
  logic [RunW-1:0]  run_q, run_d;
  logic [EndW-1:0]  end_q, end_d;
  logic             found_q, found_d;
  logic [TS_W-1:0]  tof_q, tof_d;
  logic [LOG_W-1:0] peak_q, peak_d;

  logic [LOG_W-1:0] noise;
  logic             floor_init;
  logic             floor_upd;
  logic [LOG_W:0]   limit;
  logic             above;
  logic             is_last;
  logic [TS_W-1:0]  max_last;

  log_noise_floor #(
    .LOG_W (LOG_W),
    .SHIFT (NOISE_SHIFT)
  ) u_floor (
    .clk      (clk),
    .rst      (rst),
    .init_i   (floor_init),
    .upd_i    (floor_upd),
    .sample_i (bus.in_log),
    .noise_o  (noise)
  );

  // One extra bit so floor + margin never wraps.
  assign limit    = {1'b0, noise} + {1'b0, thresh_q};
  assign above    = {1'b0, bus.in_log} > limit;
  // A window of 0 wraps to the all-ones index, i.e. 2^TS_W samples.
  assign max_last = max_q - TS_W'(1);
  assign is_last  = (idx_q == max_last);

  always_comb begin
    state_d    = state_q;
    thresh_d   = thresh_q;
    max_d      = max_q;
    idx_d      = idx_q;
    run_d      = run_q;
    end_d      = end_q;
    found_d    = found_q;
    tof_d      = tof_q;
    peak_d     = peak_q;
    floor_init = 1'b0;
    floor_upd  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          thresh_d = bus.thresh;
          max_d    = bus.max_samples;
          found_d  = 1'b0;
          tof_d    = '0;
          peak_d   = '0;
          idx_d    = '0;
          run_d    = '0;
          end_d    = '0;
          state_d  = StBlank;
        end
      end

      StBlank: begin
        if (bus.in_valid) begin
          idx_d      = idx_q + 1'b1;
          floor_init = (idx_q == '0);
          floor_upd  = (idx_q != '0);
          if (is_last) begin
            state_d = StDone;
            found_d = 1'b0;
            tof_d   = '0;
            peak_d  = '0;
          end else if (idx_q == BlankLast) begin
            state_d = StSearch;
          end
        end
      end

      StSearch: begin
        if (bus.in_valid) begin
          idx_d = idx_q + 1'b1;
          if (above) begin
            run_d = run_q + 1'b1;
            // Strict compare keeps the earliest sample of an equal plateau.
            if (run_q == '0 || bus.in_log > peak_q) begin
              peak_d = bus.in_log;
              tof_d  = idx_q;
            end
            if (run_q + 1'b1 == HoldCnt) begin
              state_d = StTrack;
              end_d   = '0;
            end
          end else begin
            run_d     = '0;
            peak_d    = '0;
            tof_d     = '0;
            floor_upd = 1'b1;
          end
          if (is_last) begin
            state_d = StDone;
            found_d = 1'b0;
            tof_d   = '0;
            peak_d  = '0;
          end
        end
      end

      StTrack: begin
        if (bus.in_valid) begin
          idx_d = idx_q + 1'b1;
          if (above) begin
            end_d = '0;
            if (bus.in_log > peak_q) begin
              peak_d = bus.in_log;
              tof_d  = idx_q;
            end
          end else begin
            end_d = end_q + 1'b1;
          end
          if (is_last || (!above && (end_q + 1'b1 == EndCnt))) begin
            state_d = StDone;
            found_d = 1'b1;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      thresh_q <= '0;
      max_q    <= '0;
      idx_q    <= '0;
      run_q    <= '0;
      end_q    <= '0;
      found_q  <= 1'b0;
      tof_q    <= '0;
      peak_q   <= '0;
    end else begin
      state_q  <= state_d;
      thresh_q <= thresh_d;
      max_q    <= max_d;
      idx_q    <= idx_d;
      run_q    <= run_d;
      end_q    <= end_d;
      found_q  <= found_d;
      tof_q    <= tof_d;
      peak_q   <= peak_d;
    end
  end

  assign bus.busy      = (state_q == StBlank) || (state_q == StSearch) || (state_q == StTrack);
  assign bus.done      = (state_q == StDone);
  assign bus.found     = found_q;
  assign bus.tof       = tof_q;
  assign bus.peak_log  = peak_q;
  assign bus.noise_log = noise;

endmodule

// File: tb/tb_log_echo_detect.sv
// Randomized and directed bench for log_echo_detect against a per-sample behavioural model.
module tb_log_echo_detect;

  localparam int unsigned BlankN = 64;
  localparam int unsigned ShiftN = 4;
  localparam int unsigned HoldN  = 4;
  localparam int unsigned EndN   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  log_echo_detect_if #(.LOG_W(21), .TS_W(16)) bus ();

  log_echo_detect #(
    .LOG_W       (21),
    .TS_W        (16),
    .BLANK       (BlankN),
    .NOISE_SHIFT (ShiftN),
    .HOLD        (HoldN),
    .END_HOLD    (EndN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int unsigned smp[$];
  int          e_end;
  bit          e_found;
  longint      e_tof;
  longint      e_peak;
  longint      e_noise;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int n, input int unsigned val);
    smp = {};
    for (int i = 0; i < n; i++) smp.push_back(val);
  endtask

  task automatic put(input int lo, input int hi, input int unsigned val);
    for (int i = lo; i <= hi; i++) smp[i] = val;
  endtask

  // Walks the sample list applying the detection rules directly; records the terminating
  // sample index and the results visible on the following cycle.
  task automatic model(input longint thr, input int unsigned maxs);
    longint nz = 0;
    int     run = 0;
    int     quiet = 0;
    bit     tracking = 0;
    int     limit_n = (maxs == 0) ? 65536 : int'(maxs);
    e_found = 0;
    e_tof   = 0;
    e_peak  = 0;
    e_end   = -1;
    for (int i = 0; i < smp.size(); i++) begin
      longint x = longint'(smp[i]);
      bit above = x > nz + thr;
      bit was_tracking = tracking;
      bit fin = 0;
      if (i == 0) nz = x;
      else if (i < int'(BlankN) || (!was_tracking && !above)) nz = nz + ((x - nz) >>> ShiftN);
      if (i >= int'(BlankN)) begin
        if (above) begin
          if (!was_tracking && run == 0) begin
            e_peak = x;
            e_tof  = i;
          end else if (x > e_peak) begin
            e_peak = x;
            e_tof  = i;
          end
          run++;
          quiet = 0;
          if (run >= int'(HoldN)) tracking = 1;
        end else if (was_tracking) begin
          quiet++;
          if (quiet == int'(EndN)) begin
            fin = 1;
            e_found = 1;
          end
        end else begin
          run    = 0;
          e_peak = 0;
          e_tof  = 0;
        end
      end
      if (!fin && i == limit_n - 1) begin
        fin = 1;
        e_found = was_tracking;
        if (!was_tracking) begin
          e_peak = 0;
          e_tof  = 0;
        end
      end
      if (fin) begin
        e_end   = i;
        e_noise = nz;
        break;
      end
    end
  endtask

  // Drives one measurement. abort_at >= 0 pulses rst after that sample; restart_at >= 0
  // raises a stray start together with that sample.
  task automatic run_meas(input string name, input logic [20:0] thr, input logic [15:0] maxs,
                          input int gap, input bit rand_gap, input int abort_at,
                          input int restart_at);
    int early = 0;
    model(longint'(thr), maxs);
    if (e_end < 0) begin
      $display("FAIL %s.model: got no terminating sample expected one", name);
      n_fail++;
      return;
    end
    @(negedge clk);
    bus.start       = 1'b1;
    bus.thresh      = thr;
    bus.max_samples = maxs;
    @(negedge clk);
    bus.start       = 1'b0;
    bus.thresh      = 21'($urandom);
    bus.max_samples = 16'($urandom);
    check_val({name, ".busy_start"}, 32'(bus.busy), 32'd1);
    check_val({name, ".found_clr"}, 32'(bus.found), 32'd0);
    for (int i = 0; i <= e_end; i++) begin
      int g = rand_gap ? int'($urandom_range(gap, 0)) : gap;
      for (int k = 0; k < g; k++) begin
        bus.in_log = 21'($urandom);
        @(negedge clk);
        if (bus.done) early++;
      end
      bus.in_valid = 1'b1;
      bus.in_log   = 21'(smp[i]);
      if (i == restart_at) begin
        bus.start       = 1'b1;
        bus.thresh      = '0;
        bus.max_samples = 16'd30;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
      if (i == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val({name, ".abort_busy"}, 32'(bus.busy), 32'd0);
        check_val({name, ".abort_done"}, 32'(bus.done), 32'd0);
        check_val({name, ".abort_found"}, 32'(bus.found), 32'd0);
        check_val({name, ".abort_tof"}, 32'(bus.tof), 32'd0);
        check_val({name, ".abort_peak"}, 32'(bus.peak_log), 32'd0);
        check_val({name, ".abort_noise"}, 32'(bus.noise_log), 32'd0);
        for (int k = 0; k < 4; k++) begin
          bus.in_valid = 1'b1;
          bus.in_log   = 21'($urandom);
          @(negedge clk);
          if (bus.done || bus.busy) early++;
        end
        bus.in_valid = 1'b0;
        check_val({name, ".abort_quiet"}, 32'(early), 32'd0);
        check_val({name, ".idle_noise"}, 32'(bus.noise_log), 32'd0);
        return;
      end
      if (i < e_end && bus.done) early++;
    end
    check_val({name, ".no_early_done"}, 32'(early), 32'd0);
    check_val({name, ".done"}, 32'(bus.done), 32'd1);
    check_val({name, ".busy_at_done"}, 32'(bus.busy), 32'd0);
    check_val({name, ".found"}, 32'(bus.found), 32'(e_found));
    check_val({name, ".tof"}, 32'(bus.tof), 32'(e_tof));
    check_val({name, ".peak"}, 32'(bus.peak_log), 32'(e_peak));
    check_val({name, ".noise"}, 32'(bus.noise_log), 32'(e_noise));
    @(negedge clk);
    check_val({name, ".done_pulse"}, 32'(bus.done), 32'd0);
    check_val({name, ".found_hold"}, 32'(bus.found), 32'(e_found));
    check_val({name, ".tof_hold"}, 32'(bus.tof), 32'(e_tof));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start       = 1'b1;
    bus.thresh      = 21'h20000;
    bus.max_samples = 16'd10;
    bus.in_valid    = 1'b1;
    bus.in_log      = 21'h12345;
    repeat (3) @(negedge clk);
    check_val("reset.busy", 32'(bus.busy), 32'd0);
    check_val("reset.done", 32'(bus.done), 32'd0);
    check_val("reset.found", 32'(bus.found), 32'd0);
    check_val("reset.tof", 32'(bus.tof), 32'd0);
    check_val("reset.peak", 32'(bus.peak_log), 32'd0);
    check_val("reset.noise", 32'(bus.noise_log), 32'd0);
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_val("idle.ignores_valid", 32'(bus.noise_log), 32'd0);

    // Floor EMA first step
    smp = {32'h40000, 32'h50000};
    run_meas("ema", 21'h20000, 16'd2, 0, 0, -1, -1);
    check_val("ema.second", 32'(bus.noise_log), 32'h41000);

    fill(1000, 32'h50000);
    put(164, 169, 32'h80000);
    put(170, 170, 32'h90000);
    run_meas("nominal", 21'h20000, 16'd1000, 0, 0, -1, 20);

    fill(300, 32'h50000);
    put(100, 102, 32'h80000);
    run_meas("burst", 21'h20000, 16'd300, 0, 0, -1, -1);

    fill(1000, 32'h50000);
    put(200, 207, 32'h88000);
    run_meas("plateau", 21'h20000, 16'd1000, 0, 0, -1, -1);

    fill(128, 32'h50000);
    put(10, 10, 32'hF0000);
    run_meas("gaps", 21'h20000, 16'd128, 5, 0, -1, -1);

    fill(300, 32'h50000);
    put(290, 299, 32'h80000);
    put(295, 295, 32'h90000);
    run_meas("track_timeout", 21'h20000, 16'd300, 0, 0, -1, -1);

    fill(1000, 32'h50000);
    put(164, 169, 32'h80000);
    put(170, 170, 32'h90000);
    run_meas("abort", 21'h20000, 16'd1000, 0, 0, 168, -1);
    run_meas("after_abort", 21'h20000, 16'd1000, 0, 0, -1, -1);

    for (int r = 0; r < 8; r++) begin
      int unsigned maxs = $urandom_range(400, 150);
      int unsigned base = 32'h40000 + $urandom_range(32'h20000, 0);
      int unsigned pos  = $urandom_range(maxs - 21, 70);
      int unsigned len  = $urandom_range(8, 1);
      int unsigned amp  = base + 32'h30000 + $urandom_range(32'hFFFF, 0);
      logic [20:0] thr  = 21'(32'h10000 + $urandom_range(32'h20000, 0));
      smp = {};
      for (int i = 0; i < int'(maxs); i++) smp.push_back(base + $urandom_range(32'hFFF, 0));
      for (int k = 0; k < int'(len); k++) smp[pos + k] = amp + $urandom_range(32'h3FFF, 0);
      run_meas($sformatf("rand%0d", r), thr, 16'(maxs), 2, 1, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
